// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sweep sequencer slice.
//  - Default widths/depths for the sequencer and its result FIFO.
//  - CORDIC_LATENCY: fixed pipeline depth of the sin/cos core.
//  - seq_state_t: sequencer FSM encoding.
package cordic_pkg;
  localparam int ANGLE_W_DEF    = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int CORDIC_LATENCY = 18;
  localparam int FIFO_DEPTH_DEF = 32;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Width able to hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/cordic_result_fifo.sv
// Synchronous first-word-fall-through FIFO for returning CORDIC samples.
// Ports:
//  clk, rst    clock / synchronous active-high reset
//  push, wdata write side (ignored when full and not popping)
//  pop         read side, effective only while valid
//  rdata       head entry, zero while empty
//  valid       FIFO non-empty
//  count       current occupancy 0..DEPTH
module cordic_result_fifo import cordic_pkg::*; #(
  parameter int W     = 64,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [W-1:0]            wdata,
  input  logic                    pop,
  output logic [W-1:0]            rdata,
  output logic                    valid,
  output logic [occ_w(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = occ_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic          empty, full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == OW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + OW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_q];
  assign valid = ~empty;
  assign count = cnt_q;
endmodule

// File: rtl/cordic_sweep_sequencer.sv
// Angle-sweep sequencer wrapped around a fixed-latency CORDIC sin/cos core.
// Issues start + i*step (mod 2^ANGLE_W) one per cycle, tracks each sample through
// the core with a 1-bit valid delay line, and queues returning cos/sin in a
// FWFT result FIFO presented as a valid/ready stream. Issue is credit-limited so
// in-flight + queued samples never exceed FIFO_DEPTH.
// Ports:
//  clk, rst                         clock / synchronous active-high reset
//  start, abort                     sweep control pulses
//  cfg_start, cfg_step, cfg_count   sweep configuration, latched on accepted start
//  angle_out                        registered angle to the core
//  cos_in, sin_in                   core results
//  out_valid/out_ready/out_cos/out_sin  result stream
//  out_index                        zero-based sweep index of head (CORDIC_SEQ_TAG_EN only)
//  busy, done                       status: RUN|DRAIN, one-cycle pulse on return to IDLE
// Build option: define CORDIC_SEQ_TAG_EN to add out_index and store it in the FIFO.
module cordic_sweep_sequencer import cordic_pkg::*; #(
  parameter int ANGLE_W        = ANGLE_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int CORDIC_LATENCY = cordic_pkg::CORDIC_LATENCY,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ANGLE_W-1:0] cfg_start,
  input  logic [ANGLE_W-1:0] cfg_step,
  input  logic [CNT_W-1:0]   cfg_count,
  output logic [ANGLE_W-1:0] angle_out,
  input  logic [DATA_W-1:0]  cos_in,
  input  logic [DATA_W-1:0]  sin_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_cos,
  output logic [DATA_W-1:0]  out_sin,
`ifdef CORDIC_SEQ_TAG_EN
  output logic [CNT_W-1:0]   out_index,
`endif
  output logic               busy,
  output logic               done
);
  localparam int CW = occ_w(FIFO_DEPTH);
  localparam int L  = CORDIC_LATENCY;
`ifdef CORDIC_SEQ_TAG_EN
  localparam int FW = CNT_W + 2*DATA_W;
`else
  localparam int FW = 2*DATA_W;
`endif

  seq_state_t         state_q, state_d;
  logic [ANGLE_W-1:0] phase_q, phase_d;
  logic [ANGLE_W-1:0] step_q, step_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [CW-1:0]      in_flight_q, in_flight_d;
  logic               done_q, done_d;
  // vld_pipe[0] accompanies angle_out; vld_pipe[L] lines up with the core result.
  logic [L:0]         vld_pipe;
  logic               issue, tap, credit_ok, accept_start;
  logic [CW:0]        credit_used;
  logic [CW-1:0]      fifo_cnt;
  logic [FW-1:0]      fifo_wdata, fifo_rdata;

  assign tap          = vld_pipe[L];
  assign accept_start = (state_q == IDLE) & start;
  assign credit_used  = {1'b0, in_flight_q} + {1'b0, fifo_cnt};
  assign credit_ok    = credit_used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    step_d   = step_q;
    angle_d  = angle_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          phase_d  = cfg_start;
          step_d   = cfg_step;
          remain_d = cfg_count;
          state_d  = (cfg_count != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        // abort takes priority over a same-cycle issue
        if (abort) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          issue    = 1'b1;
          angle_d  = phase_q;
          phase_d  = phase_q + step_q;
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (in_flight_q == '0 && fifo_cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (issue && !tap) in_flight_d = in_flight_q + CW'(1);
    if (!issue && tap) in_flight_d = in_flight_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      step_q      <= '0;
      angle_q     <= '0;
      remain_q    <= '0;
      in_flight_q <= '0;
      done_q      <= 1'b0;
      vld_pipe    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      angle_q     <= angle_d;
      remain_q    <= remain_d;
      in_flight_q <= in_flight_d;
      done_q      <= done_d;
      vld_pipe    <= {vld_pipe[L-1:0], issue};
    end
  end

`ifdef CORDIC_SEQ_TAG_EN
  // Results return in issue order, so the push count since start is the index.
  logic [CNT_W-1:0] push_idx_q, push_idx_d;

  always_comb begin
    push_idx_d = push_idx_q;
    if (accept_start) push_idx_d = '0;
    else if (tap)     push_idx_d = push_idx_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) push_idx_q <= '0;
    else     push_idx_q <= push_idx_d;
  end

  assign fifo_wdata = {push_idx_q, cos_in, sin_in};
  assign {out_index, out_cos, out_sin} = fifo_rdata;
`else
  logic unused_accept;
  assign unused_accept = accept_start;
  assign fifo_wdata = {cos_in, sin_in};
  assign {out_cos, out_sin} = fifo_rdata;
`endif

  cordic_result_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tap),
    .wdata (fifo_wdata),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .valid (out_valid),
    .count (fifo_cnt)
  );

  assign angle_out = angle_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
endmodule
